vga_to_axivid: RTL and testbench
================================

// Module: vga_to_axivid
// PURPOSE
// - Converts decoded pixel stream (valid/hsync/vsync/RGB, no backpressure) from HDMI receive path into AXI video stream.
// - Marks start-of-frame on TUSER and end-of-line on TLAST; buffers in small FIFO so the sink may stall briefly.
// - Measures active width/height; reports lock once frame geometry is stable.
// PARAMETERS
// - LGFIFO  5   log2 FIFO depth in pixels (32 entries)
// - LGDIM   16  width of dimension counters/outputs
// PORTS
// - i_clk           in   1      pixel clock; sole clock
// - i_reset_n       in   1      asynchronous, active-low reset
// - i_pix_valid     in   1      active pixel this cycle
// - i_vsync         in   1      raw vsync, either polarity
// - i_hsync         in   1      raw hsync, unused except debug
// - i_red,i_grn,i_blu in 8 each pixel colour
// - M_VID_TVALID    out  1      output beat valid
// - M_VID_TREADY    in   1      sink ready
// - M_VID_TDATA     out  24     {red, grn, blu}
// - M_VID_TLAST     out  1      last pixel of line
// - M_VID_TUSER     out  1      first pixel of frame
// - o_width         out  LGDIM  pixels in last completed line
// - o_height        out  LGDIM  lines in last completed frame
// - o_locked        out  1      geometry stable
// - o_overflow      out  1      one-cycle pulse, pixel dropped on full FIFO
// BEHAVIOUR
// - Reset (async, i_reset_n=0): FIFO empty, M_VID_TVALID=0, TDATA/TLAST/TUSER=0, o_width=o_height=0, o_locked=0, o_overflow=0, state SYNC_WAIT.
// - Frame start: first valid pixel after any vsync edge (rise or fall) seen since previous valid pixel; polarity-independent.
// - Input stage: one-pixel hold register. Pixel at cycle n gets eol=1 iff i_pix_valid=0 at n+1 (or n+1 is a frame start).
// - Latency: pixel valid at cycle n, FIFO empty, TREADY=1 -> on M_VID_* during cycle n+2. FIFO first-word-fall-through.
// - FIFO entry {sof, eol, rgb}; depth 2^LGFIFO. Beat transfers when TVALID&&TREADY; TVALID stays high and TDATA stable until accepted.
// - States: SYNC_WAIT: all pixels discarded; frame start -> write that pixel with sof=1, go RUN.
//   RUN: every pixel written. Write when full and no read same cycle -> pixel dropped, o_overflow=1 one cycle, go SYNC_WAIT.
// - Full with simultaneous read: write succeeds, no overflow.
// - Overflow: entries already in FIFO drain normally; partial line keeps eol=0 (sink resyncs on TUSER).
// - Measurement: pixel counter resets on each line; line counter increments per eol, resets at frame start. Both saturate at 2^LGDIM-1.
// - At each eol, o_width <= line pixel count. At frame start, o_height <= line count of ending frame.
// - o_locked set at frame start when ending frame had all lines equal width and width/height match prior frame.
//   Cleared on mismatch, on overflow, or on reset. First frame after reset never locks.
// - Reset mid-frame: output stream stops immediately; stream resumes only after next vsync edge + valid pixel.
// CONFIGURATION
// - VGA_TO_AXIVID_MEASURE_EN defined: width/height/lock logic as above.
// - Not defined: counters removed; o_width=0, o_height=0, o_locked=0 constant; streaming unchanged.
// TESTING
// - Reset, vsync toggle, 3 lines x 4 px (gap 2 cycles), TREADY=1 -> 12 beats, TUSER beat 0 only, TLAST beats 3/7/11, first beat at n+2.
// - Pixels before any vsync edge after reset -> no beats, TVALID stays 0.
// - Two 8x4 frames, then third 8x5 frame (macro on) -> o_width=8, o_height=4, o_locked=1 at third frame start; o_locked=0 at fourth frame start.
// - LGFIFO=2, TREADY=0, 8-px line -> o_overflow pulse on 5th px, 4 beats drain after TREADY=1, next beat carries TUSER=1 at next frame start.
// - Full FIFO, TREADY=1 same cycle as write -> no overflow, beat order preserved.
// - Assert i_reset_n=0 mid-line -> TVALID=0 same cycle; after release pixels dropped until next vsync edge; macro off -> o_width/o_height/o_locked=0 throughout.

Source files
------------

// File: rtl/vga_to_axivid_if.sv
// AXI video stream bundle between the VGA capture block and its sink.
// The master drives beats; the slave drives TREADY.
interface vga_to_axivid_if;
    logic        TVALID;
    logic        TREADY;
    logic [23:0] TDATA;
    logic        TLAST;
    logic        TUSER;

    modport master (
        output TVALID, TDATA, TLAST, TUSER,
        input  TREADY
    );
    modport slave (
        input  TVALID, TDATA, TLAST, TUSER,
        output TREADY
    );
endinterface

// File: rtl/vga_to_axivid.sv
// Decoded VGA pixel stream to AXI video stream with a small FWFT FIFO.
// Define VGA_TO_AXIVID_MEASURE_EN to enable width/height/lock measurement.
module vga_to_axivid #(
    parameter int LGFIFO = 5,
    parameter int LGDIM  = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_pix_valid,
    input  logic             i_vsync,
    input  logic             i_hsync,
    input  logic [7:0]       i_red,
    input  logic [7:0]       i_grn,
    input  logic [7:0]       i_blu,
    vga_to_axivid_if.master  M_VID,
    output logic [LGDIM-1:0] o_width,
    output logic [LGDIM-1:0] o_height,
    output logic             o_locked,
    output logic             o_overflow
);
    localparam int DEPTH = 1 << LGFIFO;

    typedef enum logic {SYNC_WAIT, RUN} state_t;
    state_t state;

    logic unused_hsync;
    assign unused_hsync = i_hsync;

    // vs_prime hides the reset-release sample so a held vsync is no edge
    logic vs_d, vs_prime, vs_pend;
    logic vs_edge, frame_start, eol_now;
    assign vs_edge     = vs_prime && (i_vsync != vs_d);
    assign frame_start = i_pix_valid && (vs_pend || vs_edge);
    assign eol_now     = !i_pix_valid || frame_start;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vs_d     <= 1'b0;
            vs_prime <= 1'b0;
            vs_pend  <= 1'b0;
        end else begin
            vs_d     <= i_vsync;
            vs_prime <= 1'b1;
            if (i_pix_valid)
                vs_pend <= 1'b0;
            else if (vs_edge)
                vs_pend <= 1'b1;
        end
    end

    logic              hold_valid, hold_sof;
    logic [23:0]       hold_rgb;
    logic [25:0]       mem [DEPTH];
    logic [25:0]       rd_word;
    logic [LGFIFO-1:0] wr_ptr, rd_ptr;
    logic [LGFIFO:0]   count;
    logic              fifo_full, rd_en, wr_en, drop;

    assign fifo_full = count == (LGFIFO+1)'(DEPTH);
    assign rd_en     = M_VID.TVALID && M_VID.TREADY;
    assign wr_en     = hold_valid && (!fifo_full || rd_en);
    assign drop      = hold_valid && fifo_full && !rd_en;
    assign rd_word   = mem[rd_ptr];

    assign M_VID.TVALID = count != '0;
    assign M_VID.TDATA  = M_VID.TVALID ? rd_word[23:0] : '0;
    assign M_VID.TLAST  = M_VID.TVALID && rd_word[24];
    assign M_VID.TUSER  = M_VID.TVALID && rd_word[25];

    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem[wr_ptr] <= {hold_sof, eol_now, hold_rgb};
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= SYNC_WAIT;
            hold_valid <= 1'b0;
            hold_sof   <= 1'b0;
            hold_rgb   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_overflow <= drop;
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (LGFIFO+1)'(wr_en)
                           - (LGFIFO+1)'(rd_en);
            if (i_pix_valid)
                hold_rgb <= {i_red, i_grn, i_blu};
            hold_valid <= 1'b0;
            hold_sof   <= 1'b0;
            // a frame start outranks a drop: that pixel opens a clean frame
            if (frame_start) begin
                state      <= RUN;
                hold_valid <= 1'b1;
                hold_sof   <= 1'b1;
            end else if (drop) begin
                state <= SYNC_WAIT;
            end else if (state == RUN) begin
                hold_valid <= i_pix_valid;
            end
        end
    end

`ifdef VGA_TO_AXIVID_MEASURE_EN
    logic             pv_d, frame_active, have_prev, uniform;
    logic [LGDIM-1:0] pix_cnt, line_cnt, w0, prev_w, prev_h;
    logic [LGDIM-1:0] pix_inc, line_inc, lines_now, w_now;
    logic             line_end, first_line, uniform_now;

    assign line_end    = pv_d && eol_now;
    assign first_line  = line_cnt == '0;
    assign pix_inc     = &pix_cnt ? pix_cnt : pix_cnt + 1'b1;
    assign line_inc    = &line_cnt ? line_cnt : line_cnt + 1'b1;
    assign lines_now   = line_end ? line_inc : line_cnt;
    assign w_now       = (line_end && first_line) ? pix_cnt : w0;
    assign uniform_now = uniform &&
        !(line_end && !first_line && pix_cnt != w0);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pv_d         <= 1'b0;
            frame_active <= 1'b0;
            have_prev    <= 1'b0;
            uniform      <= 1'b1;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            w0           <= '0;
            prev_w       <= '0;
            prev_h       <= '0;
            o_width      <= '0;
            o_height     <= '0;
            o_locked     <= 1'b0;
        end else begin
            pv_d <= i_pix_valid;
            if (!i_pix_valid)
                pix_cnt <= '0;
            else if (line_end)
                pix_cnt <= LGDIM'(1);
            else
                pix_cnt <= pix_inc;
            if (line_end) begin
                o_width  <= pix_cnt;
                line_cnt <= line_inc;
                if (first_line)
                    w0 <= pix_cnt;
                else if (pix_cnt != w0)
                    uniform <= 1'b0;
                if (have_prev && pix_cnt != prev_w)
                    o_locked <= 1'b0;
            end
            // geometry before the first frame start is not a real frame
            if (frame_start) begin
                line_cnt     <= '0;
                uniform      <= 1'b1;
                frame_active <= 1'b1;
                if (frame_active) begin
                    o_height  <= lines_now;
                    prev_w    <= w_now;
                    prev_h    <= lines_now;
                    have_prev <= 1'b1;
                    o_locked  <= have_prev && uniform_now &&
                                 w_now == prev_w &&
                                 lines_now == prev_h;
                end
            end
            if (drop)
                o_locked <= 1'b0;
        end
    end
`else
    assign o_width  = '0;
    assign o_height = '0;
    assign o_locked = 1'b0;
`endif
endmodule

// File: tb/tb_vga_to_axivid.sv
// Scoreboard bench for vga_to_axivid: expected beats are derived from
// frame/line structure and popped by an independent output monitor.
`timescale 1ns/1ps
module tb_vga_to_axivid;
    localparam int LGFIFO = 2;
    localparam int LGDIM  = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pix_valid = 1'b0;
    logic             vsync = 1'b0;
    logic             hsync = 1'b0;
    logic [7:0]       red = '0, grn = '0, blu = '0;
    logic [LGDIM-1:0] width, height;
    logic             locked, overflow;

    always #5 clk = ~clk;

    vga_to_axivid_if vid();

    vga_to_axivid #(.LGFIFO(LGFIFO), .LGDIM(LGDIM)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_pix_valid (pix_valid),
        .i_vsync     (vsync),
        .i_hsync     (hsync),
        .i_red       (red),
        .i_grn       (grn),
        .i_blu       (blu),
        .M_VID       (vid.master),
        .o_width     (width),
        .o_height    (height),
        .o_locked    (locked),
        .o_overflow  (overflow)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int beats = 0;
    int ovf_cnt = 0;
    int first_beat_cyc = -1;
    logic [25:0] expq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // output monitor: pops the scoreboard on every accepted beat
    always @(negedge clk) begin
        logic [25:0] e;
        if (rst_n) begin
            if (overflow) ovf_cnt++;
            if (vid.TVALID && vid.TREADY) begin
                beats++;
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got %h expected none",
                             {vid.TUSER, vid.TLAST, vid.TDATA});
                end else begin
                    e = expq.pop_front();
                    check("beat", 32'({vid.TUSER, vid.TLAST, vid.TDATA}),
                          32'(e));
                end
            end
        end
    end

    task automatic step(input logic v, input logic [23:0] rgb);
        pix_valid = v;
        {red, grn, blu} = v ? rgb : 24'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 24'h0);
    endtask

    task automatic vs_edge(input bit single);
        vsync = ~vsync;
        idle(2);
        if (!single) begin
            vsync = ~vsync;
            idle(2);
        end
    endtask

    task automatic send_line(input int w, input int gap,
                             input bit sof, input bit push);
        logic [23:0] rgb;
        for (int i = 0; i < w; i++) begin
            rgb = 24'($urandom);
            if (push) expq.push_back({sof && i == 0, i == w - 1, rgb});
            step(1'b1, rgb);
        end
        idle(gap);
    endtask

    task automatic send_frame(input int w, input int h,
                              input int gap, input bit single);
        vs_edge(single);
        for (int l = 0; l < h; l++) send_line(w, gap, l == 0, 1'b1);
    endtask

    task automatic check_geom(input string name, input int w,
                              input int h, input bit lk);
`ifdef VGA_TO_AXIVID_MEASURE_EN
        check({name, "_width"}, 32'(width), 32'(w));
        check({name, "_height"}, 32'(height), 32'(h));
        check({name, "_locked"}, 32'(locked), 32'(lk));
`else
        check({name, "_width"}, 32'(width), 32'(0));
        check({name, "_height"}, 32'(height), 32'(0));
        check({name, "_locked"}, 32'(locked), 32'(0));
`endif
    endtask

    initial begin
        int t0, b0, o0, w, h, g;
        logic [23:0] rgb;

        vid.TREADY = 1'b1;
        idle(3);
        check("rst_tvalid", 32'(vid.TVALID), 32'(0));
        check("rst_tdata", 32'(vid.TDATA), 32'(0));
        check("rst_tlast", 32'(vid.TLAST), 32'(0));
        check("rst_tuser", 32'(vid.TUSER), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        check_geom("rst", 0, 0, 1'b0);
        rst_n = 1'b1;
        idle(2);

        // no vsync edge since reset: everything is discarded
        send_line(4, 2, 1'b0, 1'b0);
        idle(4);
        check("pre_vsync_beats", 32'(beats), 32'(0));

        vs_edge(1'b0);
        t0 = cyc;
        for (int l = 0; l < 3; l++) send_line(4, 2, l == 0, 1'b1);
        idle(4);
        check("first_latency", 32'(first_beat_cyc), 32'(t0 + 2));
        check("beats_3x4", 32'(beats), 32'(12));

        send_frame(8, 4, 2, 1'b0);
        send_frame(8, 4, 2, 1'b0);
        vs_edge(1'b0);
        send_line(8, 2, 1'b1, 1'b1);
        check_geom("third_start", 8, 4, 1'b1);
        for (int l = 1; l < 5; l++) send_line(8, 2, 1'b0, 1'b1);
        vs_edge(1'b1);
        send_line(8, 2, 1'b1, 1'b1);
        check_geom("fourth_start", 8, 5, 1'b0);
        idle(3);

        for (int f = 0; f < 6; f++) begin
            w = $urandom_range(10, 1);
            h = $urandom_range(4, 1);
            g = $urandom_range(3, 1);
            send_frame(w, h, g, 1'($urandom_range(1)));
`ifdef VGA_TO_AXIVID_MEASURE_EN
            check("rand_width", 32'(width), 32'(w));
`endif
        end
        idle(4);

        // short stall that fits in the FIFO
        vs_edge(1'b0);
        b0 = beats;
        vid.TREADY = 1'b0;
        send_line(3, 1, 1'b1, 1'b1);
        idle(3);
        check("stall_hold", 32'(beats), 32'(b0));
        check("stall_tvalid", 32'(vid.TVALID), 32'(1));
        vid.TREADY = 1'b1;
        idle(4);
        check("stall_drain", 32'(beats), 32'(b0 + 3));

        // fifth pixel lands on a full FIFO while a beat is read
        vs_edge(1'b0);
        o0 = ovf_cnt;
        b0 = beats;
        vid.TREADY = 1'b0;
        send_line(5, 0, 1'b1, 1'b1);
        vid.TREADY = 1'b1;
        idle(8);
        check("full_rw_no_ovf", 32'(ovf_cnt), 32'(o0));
        check("full_rw_beats", 32'(beats), 32'(b0 + 5));

        // overflow: fifth pixel of an 8-px line is dropped
        vs_edge(1'b0);
        o0 = ovf_cnt;
        b0 = beats;
        vid.TREADY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rgb = 24'($urandom);
            if (i < 4) expq.push_back({i == 0, 1'b0, rgb});
            step(1'b1, rgb);
        end
        idle(2);
        check("ovf_pulse", 32'(ovf_cnt), 32'(o0 + 1));
        check("ovf_hold", 32'(beats), 32'(b0));
        vid.TREADY = 1'b1;
        idle(6);
        check("ovf_drain", 32'(beats), 32'(b0 + 4));
        send_line(4, 2, 1'b0, 1'b0);
        check("ovf_resync_wait", 32'(beats), 32'(b0 + 4));
        send_frame(4, 1, 2, 1'b0);
        idle(4);

        // reset in the middle of a line
        vs_edge(1'b0);
        rgb = 24'($urandom);
        expq.push_back({1'b1, 1'b0, rgb});
        step(1'b1, rgb);
        step(1'b1, 24'($urandom));
        step(1'b1, 24'($urandom));
        pix_valid = 1'b1;
        #2;
        check("pre_reset_tvalid", 32'(vid.TVALID), 32'(1));
        rst_n = 1'b0;
        #1;
        check("reset_tvalid", 32'(vid.TVALID), 32'(0));
        check("reset_tdata", 32'(vid.TDATA), 32'(0));
        @(posedge clk);
        #1;
        idle(2);
        rst_n = 1'b1;
        check_geom("after_reset", 0, 0, 1'b0);
        b0 = beats;
        send_line(4, 2, 1'b0, 1'b0);
        idle(3);
        check("post_reset_drop", 32'(beats), 32'(b0));
`ifndef VGA_TO_AXIVID_MEASURE_EN
        check_geom("post_reset", 0, 0, 1'b0);
`endif
        send_frame(4, 2, 2, 1'b0);

        for (int i = 0; i < 50 && expq.size() != 0; i++) idle(1);
        check("queue_drained", 32'(expq.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
